// File: rtl/generic_reader_writer_pkg.sv
// rtl/generic_reader_writer_pkg.sv - shared reader/writer types and AXI response encodings
package generic_reader_writer_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [7:0]  burst_len;
    logic [7:0]  len;
    logic [3:0]  nsaid;
    logic [63:0] addr;
  } trans_data_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    axi_resp_t   resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_default_t;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } r_state_e;

  function automatic logic is_err_resp(input axi_resp_t resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/r_handler.sv
// rtl/r_handler.sv - AXI R channel sink: counts beats, checks RLAST framing and responses, folds data into a checksum
module r_handler #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter type         r_chan_t     = generic_reader_writer_pkg::r_chan_default_t,
  parameter type         trans_data_t = generic_reader_writer_pkg::trans_data_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  r_valid_i,
  input  r_chan_t               r_data_i,
  output logic                  r_ready_o,
  input  trans_data_t           trans_data_i,
  input  logic                  enable_i,
  output logic                  ready_o,
  output logic [15:0]           beat_cnt_o,
  output logic [7:0]            resp_err_cnt_o,
  output logic                  last_err_o,
  output logic                  unexp_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  import generic_reader_writer_pkg::*;

  r_state_e state_q, state_d;

  logic [7:0]            exp_bursts_q;
  logic [8:0]            beats_per_burst_q;
  logic [7:0]            burst_cnt_q;
  logic [8:0]            beat_in_burst_q;
  logic [15:0]           beat_cnt_q;
  logic [7:0]            resp_err_cnt_q;
  logic                  last_err_q;
  logic                  unexp_q;
  logic [DATA_WIDTH-1:0] checksum_q;

  logic                  beat_fire;
  logic                  start_job;
  logic                  last_beat;
  logic                  last_burst;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  unused_bits;

  assign r_ready_o   = 1'b1;
  assign beat_fire   = r_valid_i & r_ready_o;
  assign start_job   = enable_i & (state_q == IDLE);
  assign beat_data   = r_data_i.data;
  assign last_beat   = (beat_in_burst_q + 9'd1) == beats_per_burst_q;
  assign last_burst  = ({1'b0, burst_cnt_q} + 9'd1) == {1'b0, exp_bursts_q};
  assign unused_bits = ^{r_data_i, trans_data_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_job && (trans_data_i.burst_len != 8'd0)) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (beat_fire && last_beat && last_burst) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A start in IDLE clears everything and takes priority over a stray beat in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_bursts_q      <= '0;
      beats_per_burst_q <= '0;
      burst_cnt_q       <= '0;
      beat_in_burst_q   <= '0;
      beat_cnt_q        <= '0;
      resp_err_cnt_q    <= '0;
      last_err_q        <= 1'b0;
      unexp_q           <= 1'b0;
      checksum_q        <= '0;
    end else if (start_job) begin
      exp_bursts_q      <= trans_data_i.burst_len;
      beats_per_burst_q <= {1'b0, trans_data_i.len} + 9'd1;
      burst_cnt_q       <= '0;
      beat_in_burst_q   <= '0;
      beat_cnt_q        <= '0;
      resp_err_cnt_q    <= '0;
      last_err_q        <= 1'b0;
      unexp_q           <= 1'b0;
      checksum_q        <= '0;
    end else if (beat_fire && (state_q == RECV)) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
      checksum_q <= checksum_q ^ beat_data;
      if (is_err_resp(r_data_i.resp) && (resp_err_cnt_q != 8'hFF)) begin
        resp_err_cnt_q <= resp_err_cnt_q + 8'd1;
      end
      if (r_data_i.last != last_beat) begin
        last_err_q <= 1'b1;
      end
      // The burst closes on its counted length; RLAST only feeds the framing check.
      if (last_beat) begin
        burst_cnt_q     <= burst_cnt_q + 8'd1;
        beat_in_burst_q <= '0;
      end else begin
        beat_in_burst_q <= beat_in_burst_q + 9'd1;
      end
    end else if (beat_fire) begin
      unexp_q <= 1'b1;
    end
  end

  assign ready_o        = (state_q == IDLE);
  assign beat_cnt_o     = beat_cnt_q;
  assign resp_err_cnt_o = resp_err_cnt_q;
  assign last_err_o     = last_err_q;
  assign unexp_o        = unexp_q;
  assign checksum_o     = checksum_q;

endmodule
